// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings, widths and execute-stage payload types.
// Used by execute_pipe, alu_y86 and execute_pipe_if.
package y86_pkg;

  localparam int unsigned WORD = 64;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] A_ADD = 4'h0;
  localparam logic [3:0] A_SUB = 4'h1;
  localparam logic [3:0] A_AND = 4'h2;
  localparam logic [3:0] A_XOR = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] S_AOK = 4'h8;
  localparam logic [3:0] S_HLT = 4'h4;
  localparam logic [3:0] S_ADR = 4'h2;
  localparam logic [3:0] S_INS = 4'h1;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [WORD-1:0] STACK_INC = WORD'(8);
  localparam logic [WORD-1:0] STACK_DEC = ~WORD'(7);

  typedef struct packed {
    logic [3:0]      icode;
    logic [3:0]      ifun;
    logic [3:0]      stat;
    logic [WORD-1:0] valc;
    logic [WORD-1:0] vala;
    logic [WORD-1:0] valb;
    logic [3:0]      dste;
    logic [3:0]      dstm;
    logic [3:0]      srca;
    logic [3:0]      srcb;
  } e_reg_t;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam e_reg_t E_BUBBLE = '{icode: I_NOP, ifun: 4'h0, stat: S_AOK,
                                  valc: '0, vala: '0, valb: '0,
                                  dste: RNONE, dstm: RNONE, srca: RNONE, srcb: RNONE};

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/execute_pipe_if.sv
// Decode-to-execute bundle plus execute results and hazard-control fields.
interface execute_pipe_if;

  logic                     E_bubble;
  logic [3:0]               d_icode, d_ifun, d_Stat;
  logic [y86_pkg::WORD-1:0] d_valC, d_valA, d_valB;
  logic [3:0]               d_dstE, d_dstM, d_srcA, d_srcB;
  logic [3:0]               m_Stat, W_Stat;

  logic [3:0]               E_icode, E_ifun, E_Stat;
  logic [y86_pkg::WORD-1:0] E_valA;
  logic [3:0]               E_dstM, E_srcA, E_srcB;
  logic [y86_pkg::WORD-1:0] e_valE;
  logic [3:0]               e_dstE;
  logic                     e_Cnd;
  logic                     cc_zf, cc_sf, cc_of;

  modport master (
    output E_bubble, d_icode, d_ifun, d_Stat, d_valC, d_valA, d_valB,
           d_dstE, d_dstM, d_srcA, d_srcB, m_Stat, W_Stat,
    input  E_icode, E_ifun, E_Stat, E_valA, E_dstM, E_srcA, E_srcB,
           e_valE, e_dstE, e_Cnd, cc_zf, cc_sf, cc_of
  );

  modport slave (
    input  E_bubble, d_icode, d_ifun, d_Stat, d_valC, d_valA, d_valB,
           d_dstE, d_dstM, d_srcA, d_srcB, m_Stat, W_Stat,
    output E_icode, E_ifun, E_Stat, E_valA, E_dstM, E_srcA, E_srcB,
           e_valE, e_dstE, e_Cnd, cc_zf, cc_sf, cc_of
  );

endinterface

// File: rtl/alu_y86.sv
// Combinational Y86-64 ALU: add/sub/and/xor of B op A with new ZF/SF/OF.
module alu_y86
  import y86_pkg::*;
(
  input  logic [WORD-1:0] aluA,
  input  logic [WORD-1:0] aluB,
  input  logic [3:0]      alufun,
  output logic [WORD-1:0] valE,
  output logic            zf,
  output logic            sf,
  output logic            of
);

  localparam int unsigned MSB = WORD - 1;

  always_comb begin
    valE = '0;
    of   = 1'b0;
    case (alufun)
      A_ADD: begin
        valE = aluB + aluA;
        of   = (aluA[MSB] == aluB[MSB]) && (valE[MSB] != aluA[MSB]);
      end
      A_SUB: begin
        valE = aluB - aluA;
        of   = (aluA[MSB] != aluB[MSB]) && (valE[MSB] != aluB[MSB]);
      end
      A_AND:   valE = aluB & aluA;
      A_XOR:   valE = aluB ^ aluA;
      default: valE = '0;
    endcase
    zf = (valE == '0);
    sf = valE[MSB];
  end

endmodule

// File: rtl/execute_pipe.sv
// Y86-64 execute stage: E pipeline register, ALU, CC register and condition logic.
// Optional EXEC_MISPRED_CNT_EN adds a saturating not-taken-jump counter (mispred_cnt).
module execute_pipe
  import y86_pkg::*;
(
  input logic           clk,
  input logic           reset,
  execute_pipe_if.slave ex
`ifdef EXEC_MISPRED_CNT_EN
  ,
  output logic [31:0]   mispred_cnt
`endif
);

  e_reg_t          e_d, e_q;
  cc_t             cc_d, cc_q;
  logic [WORD-1:0] alu_a, alu_b, alu_res;
  logic [3:0]      alu_fn;
  logic            alu_zf, alu_sf, alu_of;
  logic            cnd;

  always_comb begin
    e_d = E_BUBBLE;
    if (!ex.E_bubble) begin
      e_d = '{icode: ex.d_icode, ifun: ex.d_ifun, stat: ex.d_Stat,
              valc: ex.d_valC, vala: ex.d_valA, valb: ex.d_valB,
              dste: ex.d_dstE, dstm: ex.d_dstM, srca: ex.d_srcA, srcb: ex.d_srcB};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q  <= E_BUBBLE;
      cc_q <= CC_RESET;
    end else begin
      e_q  <= e_d;
      cc_q <= cc_d;
    end
  end

  // Operand and function selection by instruction class.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_fn = A_ADD;
    case (e_q.icode)
      I_CMOVXX: alu_a = e_q.vala;
      I_OPQ: begin
        alu_a  = e_q.vala;
        alu_b  = e_q.valb;
        alu_fn = e_q.ifun;
      end
      I_IRMOVQ: alu_a = e_q.valc;
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a = e_q.valc;
        alu_b = e_q.valb;
      end
      I_CALL, I_PUSHQ: begin
        alu_a = STACK_DEC;
        alu_b = e_q.valb;
      end
      I_RET, I_POPQ: begin
        alu_a = STACK_INC;
        alu_b = e_q.valb;
      end
      default: ;
    endcase
  end

  alu_y86 u_alu (
    .aluA   (alu_a),
    .aluB   (alu_b),
    .alufun (alu_fn),
    .valE   (alu_res),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of)
  );

  // Flags commit only when no later stage has raised an exception.
  always_comb begin
    cc_d = cc_q;
    if (e_q.icode == I_OPQ && ex.m_Stat == S_AOK && ex.W_Stat == S_AOK) begin
      cc_d = '{zf: alu_zf, sf: alu_sf, of: alu_of};
    end
  end

  always_comb begin
    cnd = 1'b0;
    if (e_q.icode == I_CMOVXX || e_q.icode == I_JXX) begin
      case (e_q.ifun)
        C_YES:   cnd = 1'b1;
        C_LE:    cnd = (cc_q.sf ^ cc_q.of) | cc_q.zf;
        C_L:     cnd = cc_q.sf ^ cc_q.of;
        C_E:     cnd = cc_q.zf;
        C_NE:    cnd = !cc_q.zf;
        C_GE:    cnd = !(cc_q.sf ^ cc_q.of);
        C_G:     cnd = !(cc_q.sf ^ cc_q.of) && !cc_q.zf;
        default: cnd = 1'b0;
      endcase
    end
  end

  assign ex.E_icode = e_q.icode;
  assign ex.E_ifun  = e_q.ifun;
  assign ex.E_Stat  = e_q.stat;
  assign ex.E_valA  = e_q.vala;
  assign ex.E_dstM  = e_q.dstm;
  assign ex.E_srcA  = e_q.srca;
  assign ex.E_srcB  = e_q.srcb;
  assign ex.e_valE  = alu_res;
  assign ex.e_dstE  = (e_q.icode == I_CMOVXX && !cnd) ? RNONE : e_q.dste;
  assign ex.e_Cnd   = cnd;
  assign ex.cc_zf   = cc_q.zf;
  assign ex.cc_sf   = cc_q.sf;
  assign ex.cc_of   = cc_q.of;

`ifdef EXEC_MISPRED_CNT_EN
  logic [31:0] mp_d, mp_q;

  always_comb begin
    mp_d = mp_q;
    if (e_q.icode == I_JXX && !cnd && mp_q != 32'hFFFF_FFFF) begin
      mp_d = mp_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) mp_q <= '0;
    else       mp_q <= mp_d;
  end

  assign mispred_cnt = mp_q;
`endif

endmodule

// File: doc/execute_pipe.md
Name: execute_pipe

Overview:
- Execute stage of the pipelined Y86-64 core, directly downstream of decode_wb_pipe.
- Contains three parts:
  - the E pipeline register, which captures the d_* outputs of decode;
  - the ALU;
  - the condition-code (CC) register and the condition evaluation logic.
- Produces e_valE, e_dstE and e_Cnd for the memory stage and for decode forwarding. It also exposes the E register fields needed by hazard control.

Parameters:
- WORD, 64, data width of valA/valB/valC/valE.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- E_bubble  in  1  load a bubble into the E register this edge.
- d_icode, d_ifun  in  4 each  decoded instruction fields.
- d_Stat  in  4  decode status.
- d_valC, d_valA, d_valB  in  WORD each  operands from decode.
- d_dstE, d_dstM, d_srcA, d_srcB  in  4 each  register IDs.
- m_Stat, W_Stat  in  4 each  status of the later stages, used for CC inhibit.
- E_icode, E_ifun, E_Stat  out  4 each  registered fields.
- E_valA  out  WORD  registered valA, passed to memory.
- E_dstM, E_srcA, E_srcB  out  4 each  registered IDs, for hazard control.
- e_valE  out  WORD  ALU result (combinational from the E register).
- e_dstE  out  4  destination of valE after the cmov check.
- e_Cnd  out  1  condition result.
- cc_zf, cc_sf, cc_of  out  1 each  current CC register.

Behaviour:
- Encodings:
  - icode: HALT 0, NOP 1, CMOVXX 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B.
  - Stat (one-hot): AOK 8, HLT 4, ADR 2, INS 1.
  - RNONE = 15.
- E register, updated on posedge clk:
  - If reset or E_bubble: load the bubble (icode 1, ifun 0, Stat AOK, valC/valA/valB 0, all register IDs 15).
  - Otherwise load the d_* inputs.
  - E never stalls.
- ALU operand A:
  - valA for CMOVXX and OPQ;
  - valC for IRMOVQ, RMMOVQ and MRMOVQ;
  - -8 for CALL and PUSHQ;
  - +8 for RET and POPQ;
  - 0 otherwise.
- ALU operand B:
  - valB for RMMOVQ, MRMOVQ, OPQ, CALL, PUSHQ, RET and POPQ;
  - 0 otherwise.
- ALU function:
  - For OPQ, the function is E_ifun: 0 = B+A, 1 = B-A, 2 = B&A, 3 = B^A.
  - For OPQ with ifun greater than 3, the result is 0.
  - For all other icodes the ALU adds.
  - All arithmetic wraps modulo 2^WORD.
- New flags:
  - ZF = (result == 0); SF = result[WORD-1].
  - OF for add: operands have the same sign and the result sign differs.
  - OF for sub: the signs of B and A differ and the result sign differs from B.
  - OF = 0 for logical operations.
- CC register:
  - Reset value: ZF=1, SF=0, OF=0.
  - Updated at posedge only when E_icode==OPQ, m_Stat==AOK, W_Stat==AOK and reset is low.
  - Otherwise it holds.
  - e_Cnd always reads the registered CC, never the flags being computed in the same cycle.
- e_Cnd:
  - Defined for E_icode in {CMOVXX, JXX}; 0 for every other icode.
  - Conditions by ifun: 0 always, 1 le = (SF^OF)|ZF, 2 l = SF^OF, 3 e = ZF, 4 ne = !ZF, 5 ge = !(SF^OF), 6 g = !(SF^OF)&!ZF.
  - ifun 7 or above gives 0.
- e_dstE = RNONE when E_icode==CMOVXX and e_Cnd==0; otherwise E_dstE.
- Latency: d_* appear at the E_* outputs one cycle after capture. e_valE, e_dstE and e_Cnd are valid in the same cycle as the E_* fields.
- If reset and E_bubble are asserted together, the result is the reset result.
- Reset mid-instruction discards the E contents and restores CC to its reset value.

Optional Feature:
- Macro: EXEC_MISPRED_CNT_EN.
- When defined:
  - Adds output mispred_cnt (32 bits).
  - It increments on each posedge where E_icode==JXX and e_Cnd==0, and saturates at 0xFFFFFFFF.
  - Reset value is 0.
  - Bubbles never count.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package y86_pkg holds the icode constants, ALU function codes, condition codes, Stat codes, RNONE, WORD, and the bubble field values.
- One sub-module, alu_y86: combinational; inputs aluA, aluB and alufun; outputs the result and the new ZF/SF/OF.
- The E register, CC register and condition logic stay in execute_pipe.

Test Plan:
- Reset for 1 cycle → E_icode=1, E_dstE=15, e_valE=0, e_Cnd=0, CC=(ZF1,SF0,OF0).
- d_icode=6, ifun=0, valA=3, valB=5, dstE=2 → next cycle e_valE=8, e_dstE=2. The cycle after, CC=(0,0,0).
- OPQ sub with valA=valB=7 → e_valE=0, then ZF=1. OPQ add with valA=0x7FFF_FFFF_FFFF_FFFF, valB=1 → e_valE=0x8000_0000_0000_0000, then SF=1, OF=1.
- OPQ sub with valA=valB=7 while m_Stat=2 (ADR) → e_valE=0 but CC unchanged from the previous values.
- CC=(0,0,0), then cmovle (2/1) with dstE=4 → e_Cnd=0, e_dstE=15. With CC ZF=1 → e_Cnd=1, e_dstE=4.
- E_bubble=1 with d_icode=6 → E_icode=1, CC unchanged. PUSHQ with valB=100 → e_valE=92. POPQ with valB=100 → e_valE=108. With EXEC_MISPRED_CNT_EN defined, a not-taken jne → mispred_cnt=1.
